// File: rtl/approx_err_pkg.sv
// approx_err_pkg: FSM states, default widths and saturating-add helpers shared by the approx_err_monitor slice
package approx_err_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;
  localparam int unsigned DEF_FRAME_LEN = 65536;
  localparam int SAT_W = 128;
  function automatic logic [SAT_W:0] sat_lim(input int unsigned w);
    return ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
  endfunction
  function automatic logic add_ovf(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b, input int unsigned w);
    return ({1'b0, a} + {1'b0, b}) > sat_lim(w);
  endfunction
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b, input int unsigned w);
    return add_ovf(a, b, w) ? SAT_W'(sat_lim(w)) : a + b;
  endfunction
endpackage

// File: rtl/approx_err_dist.sv
// approx_err_dist: stage-1 register of |exact_i-approx_i| with valid (flush_i drops the incoming sample); sq_o=ed^2 when APPROX_ERR_MSE_EN
module approx_err_dist #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH:0]   exact_i,
  input  logic [WIDTH:0]   approx_i,
`ifdef APPROX_ERR_MSE_EN
  output logic [2*WIDTH+1:0] sq_o,
`endif
  output logic             valid_o,
  output logic [WIDTH:0]   ed_o
);
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0] ed_d, ed_q;
  logic valid_q;
  assign diff = {1'b0, exact_i} - {1'b0, approx_i};
  assign ed_d = (WIDTH+1)'(diff[WIDTH+1] ? -diff : diff);
  assign valid_o = valid_q;
  assign ed_o = ed_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      ed_q <= '0;
    end else begin
      valid_q <= valid_i && !flush_i;
      if (valid_i) ed_q <= ed_d;
    end
`ifdef APPROX_ERR_MSE_EN
  logic [2*WIDTH+1:0] sq_q;
  assign sq_o = sq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sq_q <= '0;
    else if (valid_i) sq_q <= (2*WIDTH+2)'(ed_d) * (2*WIDTH+2)'(ed_d);
`endif
endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: frame error statistics of an approximate adder (in: start,in_valid,exact_sum,approx_sum; out: in_ready,busy,done,total_cases,error_cases,total_ed,max_ed,acc_ovf, plus sq_err under APPROX_ERR_MSE_EN)
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int          ACC_W     = DEF_ACC_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     exact_sum,
  input  logic [WIDTH:0]     approx_sum,
`ifdef APPROX_ERR_MSE_EN
  output logic [2*ACC_W-1:0] sq_err,
`endif
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   total_cases,
  output logic [CNT_W-1:0]   error_cases,
  output logic [ACC_W-1:0]   total_ed,
  output logic [WIDTH:0]     max_ed,
  output logic               acc_ovf
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tc_q, tc_d, ec_q, ec_d;
  logic [ACC_W-1:0] ted_q, ted_d;
  logic [WIDTH:0] max_q, max_d, ed;
  logic ovf_q, ovf_d, v1, accept, upd, sat;
  assign in_ready = state_q == RUN && cnt_q < CNT_W'(FRAME_LEN);
  // a start cycle restarts the frame, so anything offered or in flight then is discarded
  assign accept = in_valid && in_ready && !start;
  assign upd = v1 && !start;
`ifdef APPROX_ERR_MSE_EN
  logic [2*WIDTH+1:0] sq;
  logic [2*ACC_W-1:0] sq_q, sq_d;
  assign sat = add_ovf(SAT_W'(ted_q), SAT_W'(ed), ACC_W) | add_ovf(SAT_W'(sq_q), SAT_W'(sq), 2*ACC_W);
  assign sq_d = start ? '0 : upd ? (2*ACC_W)'(sat_add(SAT_W'(sq_q), SAT_W'(sq), 2*ACC_W)) : sq_q;
  assign sq_err = sq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sq_q <= '0;
    else sq_q <= sq_d;
`else
  assign sat = add_ovf(SAT_W'(ted_q), SAT_W'(ed), ACC_W);
`endif
  approx_err_dist #(.WIDTH(WIDTH)) u_dist (
    .clk(clk),
    .rst(rst),
    .flush_i(start),
    .valid_i(accept),
    .exact_i(exact_sum),
    .approx_i(approx_sum),
`ifdef APPROX_ERR_MSE_EN
    .sq_o(sq),
`endif
    .valid_o(v1),
    .ed_o(ed)
  );
  // DRAIN lasts one cycle: the last sample sits in stage 1 and is folded in on the DRAIN edge
  always_comb begin
    state_d = start ? RUN : state_q == RUN ? (accept && cnt_q == CNT_W'(FRAME_LEN - 1) ? DRAIN : RUN) : state_q == DRAIN ? DONE : IDLE;
    cnt_d = start ? '0 : cnt_q + CNT_W'(accept);
    tc_d = start ? '0 : tc_q + CNT_W'(upd);
    ec_d = start ? '0 : ec_q + CNT_W'(upd && ed != '0);
    ted_d = start ? '0 : upd ? ACC_W'(sat_add(SAT_W'(ted_q), SAT_W'(ed), ACC_W)) : ted_q;
    max_d = start ? '0 : (upd && ed > max_q) ? ed : max_q;
    ovf_d = start ? 1'b0 : ovf_q | (upd & sat);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tc_q <= '0;
      ec_q <= '0;
      ted_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tc_q <= tc_d;
      ec_q <= ec_d;
      ted_q <= ted_d;
      max_q <= max_d;
      ovf_q <= ovf_d;
    end
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign total_cases = tc_q;
  assign error_cases = ec_q;
  assign total_ed = ted_q;
  assign max_ed = max_q;
  assign acc_ovf = ovf_q;
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: randomized and directed frames on two monitor instances checked against a queue-based model
module tb_approx_err_monitor;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [8:0] exact_sum = '0, approx_sum = '0;
  logic m_ready, m_busy, m_done, m_ovf, s_ready, s_busy, s_done, s_ovf;
  logic [31:0] m_tc, m_ec, s_tc, s_ec;
  logic [47:0] m_ted;
  logic [3:0] s_ted;
  logic [8:0] m_max, s_max;
`ifdef APPROX_ERR_MSE_EN
  logic [95:0] m_sq;
  logic [7:0] s_sq;
`endif
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  int ex_q[$], ap_q[$];

  always #5 clk = ~clk;
  always @(negedge clk) if (m_done) done_cnt++;

  approx_err_monitor #(.WIDTH(8), .CNT_W(32), .ACC_W(48), .FRAME_LEN(4)) u_main (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(m_ready),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
`ifdef APPROX_ERR_MSE_EN
    .sq_err(m_sq),
`endif
    .busy(m_busy), .done(m_done), .total_cases(m_tc), .error_cases(m_ec),
    .total_ed(m_ted), .max_ed(m_max), .acc_ovf(m_ovf)
  );

  approx_err_monitor #(.WIDTH(8), .CNT_W(32), .ACC_W(4), .FRAME_LEN(3)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
`ifdef APPROX_ERR_MSE_EN
    .sq_err(s_sq),
`endif
    .busy(s_busy), .done(s_done), .total_cases(s_tc), .error_cases(s_ec),
    .total_ed(s_ted), .max_ed(s_max), .acc_ovf(s_ovf)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input int which);
    longint ted = 0, sq = 0, lim, sqlim;
    int ec = 0, mx = 0, ed;
    logic ovf;
    lim = which != 0 ? 64'd15 : (64'd1 << 48) - 64'd1;
    sqlim = which != 0 ? 64'd255 : 64'h7fff_ffff_ffff_ffff;
    foreach (ex_q[i]) begin
      ed = ex_q[i] > ap_q[i] ? ex_q[i] - ap_q[i] : ap_q[i] - ex_q[i];
      ec += int'(ed != 0);
      ted += ed;
      sq += longint'(ed) * ed;
      mx = ed > mx ? ed : mx;
    end
    ovf = ted > lim;
`ifdef APPROX_ERR_MSE_EN
    ovf = ovf | (sq > sqlim);
    check("sq_err", which != 0 ? 128'(s_sq) : 128'(m_sq), 128'(sq > sqlim ? sqlim : sq));
`endif
    check("total_cases", which != 0 ? 128'(s_tc) : 128'(m_tc), 128'(ex_q.size()));
    check("error_cases", which != 0 ? 128'(s_ec) : 128'(m_ec), 128'(ec));
    check("total_ed", which != 0 ? 128'(s_ted) : 128'(m_ted), 128'(ted > lim ? lim : ted));
    check("max_ed", which != 0 ? 128'(s_max) : 128'(m_max), 128'(mx));
    check("acc_ovf", which != 0 ? 128'(s_ovf) : 128'(m_ovf), 128'(ovf));
  endtask

  task automatic start_pulse(input logic v, input int e, input int a);
    start = 1;
    in_valid = v;
    exact_sum = 9'(e);
    approx_sum = 9'(a);
    @(negedge clk);
    start = 0;
    in_valid = 0;
    check("clear_on_start_main", 128'(m_tc), 0);
    check("clear_on_start_sat", 128'(s_max), 0);
    check("ready_after_start", 128'(m_ready), 1);
  endtask

  task automatic feed(input int which, input int gmin, input int gmax);
    int n = ex_q.size();
    for (int i = 0; i < n; i++) begin
      int g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        in_valid = 0;
        check("ready_gap", which != 0 ? 128'(s_ready) : 128'(m_ready), 1);
        @(negedge clk);
      end
      in_valid = 1;
      exact_sum = 9'(ex_q[i]);
      approx_sum = 9'(ap_q[i]);
      check("ready", which != 0 ? 128'(s_ready) : 128'(m_ready), 1);
      @(negedge clk);
    end
    in_valid = 0;
    check("ready_after_last", which != 0 ? 128'(s_ready) : 128'(m_ready), 0);
    check("done_early", which != 0 ? 128'(s_done) : 128'(m_done), 0);
    check("latency_cases", which != 0 ? 128'(s_tc) : 128'(m_tc), 128'(n - 1));
    @(negedge clk);
    check("done", which != 0 ? 128'(s_done) : 128'(m_done), 1);
    check_results(which);
    @(negedge clk);
    check("done_one_cycle", which != 0 ? 128'(s_done) : 128'(m_done), 0);
    check("busy_idle", which != 0 ? 128'(s_busy) : 128'(m_busy), 0);
    check("hold_cases", which != 0 ? 128'(s_tc) : 128'(m_tc), 128'(n));
  endtask

  task automatic fill_random(input int n);
    int hi = $urandom_range(1, 0) != 0 ? 511 : 7;
    ex_q.delete();
    ap_q.delete();
    for (int i = 0; i < n; i++) begin
      int e = int'($urandom_range(hi, 0));
      ex_q.push_back(e);
      ap_q.push_back($urandom_range(3, 0) == 0 ? e : int'($urandom_range(hi, 0)));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(m_ready), 0);
    check("rst_busy", 128'(m_busy), 0);
    check("rst_done", 128'(m_done), 0);
    check("rst_cases", 128'(m_tc), 0);
    check("rst_ted", 128'(m_ted), 0);
    check("rst_ovf", 128'(s_ovf), 0);
    rst = 0;
    @(negedge clk);
    check("idle_ready", 128'(m_ready), 0);

    ex_q = '{10, 10, 5, 0};
    ap_q = '{10, 8, 9, 3};
    start_pulse(0, 0, 0);
    feed(0, 0, 0);
    check("basic_ted_const", 128'(m_ted), 9);
    start_pulse(0, 0, 0);
    feed(0, 1, 3);

    ex_q = '{511, 511, 0};
    ap_q = '{0, 0, 0};
    start_pulse(0, 0, 0);
    feed(1, 0, 0);
    ex_q = '{511, 300};
    ap_q = '{511, 300};
    ex_q.push_back(511);
    ap_q.push_back(511);
    start_pulse(0, 0, 0);
    feed(1, 0, 1);

    done_cnt = 0;
    ex_q = '{13, 4};
    ap_q = '{2, 9};
    start_pulse(0, 0, 0);
    foreach (ex_q[i]) begin
      in_valid = 1;
      exact_sum = 9'(ex_q[i]);
      approx_sum = 9'(ap_q[i]);
      @(negedge clk);
    end
    start_pulse(1, 500, 0);
    check("restart_max", 128'(m_max), 0);
    ex_q = '{7, 7, 7, 7};
    ap_q = '{7, 7, 7, 7};
    feed(0, 0, 1);
    check("restart_done_count", 128'(done_cnt), 1);

    done_cnt = 0;
    ex_q = '{100, 3, 200, 0};
    ap_q = '{0, 50, 1, 255};
    start_pulse(0, 0, 0);
    foreach (ex_q[i]) begin
      in_valid = 1;
      exact_sum = 9'(ex_q[i]);
      approx_sum = 9'(ap_q[i]);
      @(negedge clk);
    end
    in_valid = 0;
    check("drain_busy", 128'(m_busy), 1);
    check("drain_cases", 128'(m_tc), 3);
    #2 rst = 1;
    #1;
    check("arst_cases", 128'(m_tc), 0);
    check("arst_ted", 128'(m_ted), 0);
    check("arst_max", 128'(m_max), 0);
    check("arst_busy", 128'(m_busy), 0);
    check("arst_ready", 128'(m_ready), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    check("arst_no_done", 128'(done_cnt), 0);

    for (int f = 0; f < 12; f++) begin
      fill_random(4);
      start_pulse(0, 0, 0);
      feed(0, 0, 2);
    end
    for (int f = 0; f < 8; f++) begin
      fill_random(3);
      start_pulse(0, 0, 0);
      feed(1, 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
